ym_phase_sched: RTL and testbench
=================================

# ym_phase_sched

Phase and write scheduler for the shift-register/latch datapath of the sound core. It divides MCLK into the non-overlapping `c1`/`c2` transfer enables that clock every `ym_sr_bit` chain, tracks the channel slot, and owns the register-file latches. It serialises host register writes into a single one-hot latch-enable strobe placed strictly between `c1` and `c2`, so latch contents never change while a shift transfer is in flight. It sits between the host bus interface and the tone/noise datapath.

## Interface
- `DIV`, default 4: MCLK cycles per phase. Full `c1`→`c1` period is 2·DIV. Legal range ≥2.
- `SLOTS`, default 4: channel slots per frame. Legal range ≥2.
- `AW`, default 3: latch address width; NLAT = 2^AW latches.
- `DW`, default 8: latch data width.
- `MCLK`, in, 1: clock.
- `RESET_n`, in, 1: reset. Asynchronous, active-low.
- `en`, in, 1: run enable. Low freezes the phase counter and suppresses strobes.
- `c1`, out, 1: shift-register load enable, one MCLK wide.
- `c2`, out, 1: shift-register transfer enable, one MCLK wide.
- `slot`, out, clog2(SLOTS): current channel slot.
- `slot_start`, out, 1: `c1` coinciding with slot 0.
- `wr_req`, in, 1: host write request, 4-phase.
- `wr_addr`, in, AW: latch index.
- `wr_data`, in, DW: latch data.
- `wr_ack`, out, 1: write-complete acknowledge.
- `lat_en`, out, NLAT: one-hot latch enable, one MCLK wide.
- `lat_data`, out, DW: data for latch inputs.
- `busy`, out, 1: a write is captured and not yet acknowledged.

## Operation
- **Phase counter `cnt`** runs 0..2·DIV−1 and wraps. It advances only when `en`=1.
- `c1`=1 in the cycle where `cnt`==0. `c2`=1 in the cycle where `cnt`==DIV. Both are registered outputs.
- **Write window:** the cycle where `cnt`==WIN, with WIN = DIV/2 (floor). This window never coincides with `c1` or `c2`.
- **Slot counter:** `slot` increments on the edge that ends a `c2` cycle and wraps SLOTS−1→0.
- `slot_start` = `c1` & (`slot`==0).
- **Write FSM:**
  - IDLE: when `wr_req`=1, capture `wr_addr`/`wr_data` into `lat_data`/addr register and go to PEND.
  - PEND: wait for the first window cycle after capture that has `en`=1. In that cycle drive `lat_en`[addr]=1 for exactly one cycle, then go to ACK.
  - ACK: `wr_ack`=1. Stay in ACK until `wr_req` is sampled 0, then go to IDLE. `wr_ack` drops in the same edge.
- `busy`=1 in PEND and ACK.
- `lat_data` is stable from capture until the next capture. `wr_addr`/`wr_data` changes after capture are ignored.
- **`en`=0:**
  - `cnt` and `slot` hold.
  - `c1`, `c2` and `lat_en` are 0.
  - PEND waits.
  - ACK still completes normally.
- **Reset (any time, including mid-write):**
  - `cnt`=0, `slot`=0, FSM=IDLE.
  - `c1`, `c2`, `slot_start`, `wr_ack`, `busy` = 0.
  - `lat_en` = 0, `lat_data` = 0.
  - A pending write is dropped and is not applied; the host must re-request.

## Timing
- `c1` period is 2·DIV cycles. `c2` follows `c1` by exactly DIV cycles. `lat_en` follows `c1` by exactly WIN cycles.
- With `en` held high after reset release, the first `c1` is in the cycle after the 2·DIV-th rising edge. The counter starts at 0, but the registered `c1` for `cnt`==0 first asserts at the first wrap.
- **Write latency**, from the capture edge to the `lat_en` cycle: 1 to 2·DIV cycles, with `en` high.
- `wr_ack` rises on the edge that ends the `lat_en` cycle.
- A new request is accepted no earlier than one cycle after `wr_ack` falls.
- **`wr_req` rising in the window cycle itself:** that window is missed, and `lat_en` lands 2·DIV cycles later.
- Only one `lat_en` bit is ever set. It is never asserted in a `c1` or `c2` cycle.

## Test plan
- **Phase generation** (DIV=4, SLOTS=4, `en`=1 after reset release): `c1` pulses every 8 cycles, `c2` 4 cycles after each `c1`. `slot` steps 0,1,2,3,0. `slot_start` is seen every 32 cycles. `c1` and `c2` never overlap.
- **Basic write:** `wr_req` with addr=3, data=0xA5 while in IDLE. Required: `busy`=1 next cycle; `lat_en`=8'b0000_1000 for one cycle exactly when `cnt`==2; `lat_data`=0xA5; `wr_ack`=1 from the following cycle until `wr_req` drops, then `wr_ack`=0 and `busy`=0.
- **Window collision:** assert `wr_req` so that capture happens in the `cnt`==2 cycle. Required: `lat_en` appears 8 cycles later, not in the same frame.
- **`en` gating:** drop `en` while in PEND for 20 cycles. Required: `c1`, `c2` and `lat_en` stay 0 and `cnt`/`slot` hold. Raise `en`: the write completes at the next window.
- **Reset mid-write:** pull `RESET_n` low while in PEND with addr=5. Required: all outputs 0 asynchronously and no `lat_en` pulse ever appears. After release, phase generation restarts per the first scenario.
- **Back-to-back writes** to addr 0 (data 0x11) and addr 7 (data 0x22), with `wr_req` re-raised one cycle after `wr_ack` falls. Required: two separate `lat_en` pulses in distinct windows, each carrying the correct data, and no `wr_ack` without a preceding `lat_en`.

Source files
------------

// File: rtl/ym_phase_sched.sv
// Phase and write scheduler: c1/c2 transfer enables, slot tracking and
// one-hot latch strobes placed between c1 and c2.
module ym_phase_sched #(
    parameter int DIV   = 4,
    parameter int SLOTS = 4,
    parameter int AW    = 3,
    parameter int DW    = 8,
    localparam int NLAT = 2 ** AW,
    localparam int SW   = $clog2(SLOTS)
) (
    input  logic            MCLK,
    input  logic            RESET_n,
    input  logic            en,
    output logic            c1,
    output logic            c2,
    output logic [SW-1:0]   slot,
    output logic            slot_start,
    input  logic            wr_req,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_ack,
    output logic [NLAT-1:0] lat_en,
    output logic [DW-1:0]   lat_data,
    output logic            busy
);

    localparam int PER = 2 * DIV;
    localparam int CW  = $clog2(PER);

    localparam logic [CW-1:0] CNT_MAX = CW'(PER - 1);
    localparam logic [CW-1:0] CNT_C2  = CW'(DIV);
    localparam logic [CW-1:0] CNT_WIN = CW'(DIV / 2);
    localparam logic [SW-1:0] SLOT_MX = SW'(SLOTS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_STRB = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_slot;
    logic            r_c1;
    logic            r_c2;
    logic [1:0]      r_state;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [NLAT-1:0] r_lat_en;

    logic [CW-1:0]   w_cnt_nxt;
    logic            w_win;
    logic [NLAT-1:0] w_onehot;

    // Outputs are registered from the next count so they align with cnt.
    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    assign w_win     = en && (w_cnt_nxt == CNT_WIN);
    assign w_onehot  = {{(NLAT-1){1'b0}}, 1'b1} << r_addr;

    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cnt  <= '0;
            r_slot <= '0;
            r_c1   <= 1'b0;
            r_c2   <= 1'b0;
        end else begin
            if (en) begin
                r_cnt <= w_cnt_nxt;
            end
            if (en && (r_cnt == CNT_C2)) begin
                r_slot <= (r_slot == SLOT_MX) ? '0 : r_slot + 1'b1;
            end
            r_c1 <= en && (w_cnt_nxt == '0);
            r_c2 <= en && (w_cnt_nxt == CNT_C2);
        end
    end

    // The window entered on the capture edge is skipped: PEND is not yet set.
    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_lat_en <= '0;
        end else begin
            r_lat_en <= '0;
            case (r_state)
                S_IDLE: begin
                    if (wr_req) begin
                        r_addr  <= wr_addr;
                        r_data  <= wr_data;
                        r_state <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (w_win) begin
                        r_lat_en <= w_onehot;
                        r_state  <= S_STRB;
                    end
                end
                S_STRB: begin
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (!wr_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign c1         = r_c1;
    assign c2         = r_c2;
    assign slot       = r_slot;
    assign slot_start = r_c1 && (r_slot == '0);
    assign wr_ack     = (r_state == S_ACK);
    assign busy       = (r_state != S_IDLE);
    assign lat_en     = r_lat_en;
    assign lat_data   = r_data;

endmodule

// File: tb/tb_ym_phase_sched.sv
// Directed bench for ym_phase_sched: phase generation, writes, en gating,
// reset mid-write and back-to-back writes.
module tb_ym_phase_sched;

    logic       MCLK;
    logic       RESET_n;
    logic       en;
    logic       c1;
    logic       c2;
    logic [1:0] slot;
    logic       slot_start;
    logic       wr_req;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [7:0] lat_en;
    logic [7:0] lat_data;
    logic       busy;

    int n_chk;
    int n_err;
    int ph;
    int ms;
    bit mc1;
    bit mc2;

    ym_phase_sched dut (
        .MCLK       (MCLK),
        .RESET_n    (RESET_n),
        .en         (en),
        .c1         (c1),
        .c2         (c2),
        .slot       (slot),
        .slot_start (slot_start),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .lat_en     (lat_en),
        .lat_data   (lat_data),
        .busy       (busy)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock; model phase/slot and check the always-true relations.
    task automatic tick();
        logic e;
        logic r;
        int   old;
        e = en;
        r = RESET_n;
        @(posedge MCLK);
        #1;
        if (!r) begin
            ph  = 0;
            ms  = 0;
            mc1 = 0;
            mc2 = 0;
        end else begin
            if (e) begin
                old = ph;
                ph  = (ph + 1) % 8;
                if (old == 4) ms = (ms + 1) % 4;
            end
            mc1 = e && (ph == 0);
            mc2 = e && (ph == 4);
        end
        chk("c1", 32'(c1), 32'(mc1));
        chk("c2", 32'(c2), 32'(mc2));
        chk("slot", 32'(slot), ms);
        chk("slot_start", 32'(slot_start), 32'(mc1 && (ms == 0)));
        chk("lat_onehot", 32'($countones(lat_en) <= 1), 32'd1);
        chk("lat_vs_c", 32'((lat_en != 0) && (c1 || c2)), 32'd0);
    endtask

    task automatic wait_ph(input int p);
        for (int n = 0; n < 20 && ph != p; n++) tick();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        logic       seen;
        logic [7:0] oh;
        oh      = 8'h01 << a;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        seen    = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (lat_en != 0) seen = 1'b1;
            else chk("b2b_noack", 32'(wr_ack), 32'd0);
        end
        chk("b2b_seen", 32'(seen), 32'd1);
        chk("b2b_lat", 32'(lat_en), 32'(oh));
        chk("b2b_data", 32'(lat_data), 32'(d));
        chk("b2b_win", ph, 32'd2);
        tick();
        chk("b2b_ack", 32'(wr_ack), 32'd1);
        chk("b2b_lat0", 32'(lat_en), 32'd0);
        wr_req = 1'b0;
        tick();
        chk("b2b_ack0", 32'(wr_ack), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        ph      = 0;
        ms      = 0;
        RESET_n = 1'b0;
        en      = 1'b1;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(wr_ack), 32'd0);
        chk("rst_lat", 32'(lat_en), 32'd0);
        chk("rst_data", 32'(lat_data), 32'd0);
        RESET_n = 1'b1;

        // Phase generation over five frames
        repeat (40) tick();

        // Basic write; later bus changes must be ignored
        wait_ph(6);
        wr_addr = 3'd3;
        wr_data = 8'hA5;
        wr_req  = 1'b1;
        tick();
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_lat_early", 32'(lat_en), 32'd0);
        wr_addr = 3'd0;
        wr_data = 8'h00;
        tick();
        chk("wr_lat_p0", 32'(lat_en), 32'd0);
        tick();
        chk("wr_lat_p1", 32'(lat_en), 32'd0);
        tick();
        chk("wr_lat", 32'(lat_en), 32'h08);
        chk("wr_data", 32'(lat_data), 32'hA5);
        chk("wr_ack_early", 32'(wr_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_ack", 32'(wr_ack), 32'd1);
            chk("wr_lat_off", 32'(lat_en), 32'd0);
            chk("wr_busy_ack", 32'(busy), 32'd1);
        end
        wr_req = 1'b0;
        tick();
        chk("wr_ack_drop", 32'(wr_ack), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);
        chk("wr_data_hold", 32'(lat_data), 32'hA5);

        // Capture lands in the window cycle: next frame's window is used
        wait_ph(1);
        wr_addr = 3'd1;
        wr_data = 8'h3C;
        wr_req  = 1'b1;
        tick();
        chk("col_busy", 32'(busy), 32'd1);
        chk("col_lat0", 32'(lat_en), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("col_lat", 32'(lat_en), (i == 8) ? 32'h02 : 32'h00);
        end
        chk("col_data", 32'(lat_data), 32'h3C);
        tick();
        chk("col_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        tick();
        chk("col_idle", 32'(busy), 32'd0);

        // en gating while pending
        wait_ph(4);
        wr_addr = 3'd6;
        wr_data = 8'h5A;
        wr_req  = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("en_lat", 32'(lat_en), 32'd0);
            chk("en_busy", 32'(busy), 32'd1);
            chk("en_ack", 32'(wr_ack), 32'd0);
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("en_resume", 32'(lat_en), (i == 5) ? 32'h40 : 32'h00);
        end
        chk("en_data", 32'(lat_data), 32'h5A);
        tick();
        chk("en_ack1", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        tick();
        chk("en_idle", 32'(busy), 32'd0);

        // Reset while pending: write must be dropped
        wait_ph(3);
        wr_addr = 3'd5;
        wr_data = 8'h99;
        wr_req  = 1'b1;
        tick();
        chk("rm_busy", 32'(busy), 32'd1);
        tick();
        RESET_n = 1'b0;
        wr_req  = 1'b0;
        #2;
        chk("rm_c1", 32'(c1), 32'd0);
        chk("rm_c2", 32'(c2), 32'd0);
        chk("rm_slot", 32'(slot), 32'd0);
        chk("rm_sstart", 32'(slot_start), 32'd0);
        chk("rm_ack", 32'(wr_ack), 32'd0);
        chk("rm_busy0", 32'(busy), 32'd0);
        chk("rm_lat", 32'(lat_en), 32'd0);
        chk("rm_data", 32'(lat_data), 32'd0);
        repeat (3) tick();
        RESET_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("rm_nolat", 32'(lat_en), 32'd0);
            chk("rm_idle", 32'(busy), 32'd0);
        end

        // Back-to-back writes
        do_write(3'd0, 8'h11);
        tick();
        do_write(3'd7, 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
